pwm_sample_feeder: RTL and testbench

Wishbone-slave sample buffer sitting directly upstream of the 8-bit PWM DAC stage in the pedal's audio output path. The CPU writes 8-bit samples into a small FIFO; a frame-rate counter pops one sample per PWM frame (12001 clk cycles, about 4 kHz) and presents it on `pwmin` together with the chip-select and start strobes the PWM stage expects. Underrun and overflow are flagged sticky so firmware can detect a starved or overfed output.

---
 rtl/pwm_sample_feeder_pkg.sv | 25 ++
 rtl/pwm_sample_feeder_sample_fifo.sv | 69 ++++++
 rtl/pwm_sample_feeder.sv | 162 ++++++++++++++++
 tb/tb_pwm_sample_feeder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sample_feeder_pkg.sv
// Shared definitions for the PWM sample feeder: register map, bit positions
// and the mid-scale idle sample.
package pwm_sample_feeder_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_ERR    = 2'd3
    } reg_adr_e;

    localparam int STATUS_EMPTY = 5;
    localparam int STATUS_FULL  = 6;
    localparam int STATUS_ERR   = 7;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_ERR = 2;

    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_OVERFLOW = 1;

    localparam logic [7:0] IDLE_SAMPLE_DEF = 8'h80;

endpackage

// File: rtl/pwm_sample_feeder_sample_fifo.sv
// Synchronous DEPTH x 8 sample FIFO with flush; a push while full is accepted
// only when a pop happens in the same cycle.
module pwm_sample_feeder_sample_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pwm_sample_feeder.sv
// Wishbone sample buffer feeding the 8-bit PWM DAC, one sample per FRAME cycles.
// Optional low-water interrupt output enabled by defining PWM_FEEDER_IRQ_EN.
module pwm_sample_feeder
    import pwm_sample_feeder_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         FRAME       = 12001,
    parameter logic [7:0] IDLE_SAMPLE = IDLE_SAMPLE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [1:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic [7:0] pwmin,
    output logic       cspwm,
    output logic       start_tx_in
`ifdef PWM_FEEDER_IRQ_EN
    ,
    output logic       irq
`endif
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic          ack_q, ack_d;
    logic [7:0]    dat_o_q, dat_o_d;
    logic          we_q, we_d;
    logic [1:0]    adr_q, adr_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          en_q, en_d;
    logic [1:0]    err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    pwmin_q, pwmin_d;
    logic          start_q, start_d;
    logic [3:0]    thr_rd;

    logic          req, data_wr, ctrl_wr, flush, clr_err, tick;
    logic          push, pop, underrun, overflow;
    logic [7:0]    rdata, fifo_dout;
    logic [LW-1:0] fifo_level;
    logic          fifo_full, fifo_empty;

    // Register side effects act on the latched access during the ack cycle.
    assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign data_wr  = ack_q & we_q & (adr_q == REG_DATA);
    assign ctrl_wr  = ack_q & we_q & (adr_q == REG_CTRL);
    assign flush    = ctrl_wr & wdat_q[CTRL_FLUSH];
    assign clr_err  = ctrl_wr & wdat_q[CTRL_CLR_ERR];
    assign tick     = en_q & (cnt_q == LAST);
    assign pop      = tick & ~fifo_empty & ~flush;
    assign push     = data_wr & ~flush;
    assign underrun = tick & fifo_empty & ~flush;
    assign overflow = push & fifo_full & ~pop;

    pwm_sample_feeder_sample_fifo #(.DEPTH(DEPTH)) u_sample_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (wdat_q),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef PWM_FEEDER_IRQ_EN
    logic [3:0] thr_q, thr_d;
    logic       irq_q, irq_d;

    assign thr_rd = thr_q;
    assign irq    = irq_q;

    always_comb begin
        thr_d = ctrl_wr ? wdat_q[7:4] : thr_q;
        irq_d = (en_q & (int'(fifo_level) <= int'(thr_q))) | (|err_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_q <= '0;
            irq_q <= 1'b0;
        end else begin
            thr_q <= thr_d;
            irq_q <= irq_d;
        end
    end
`else
    assign thr_rd = 4'h0;
`endif

    always_comb begin
        rdata = 8'h00;
        case (wb_adr_i)
            REG_STATUS: rdata = {|err_q, fifo_full, fifo_empty, 5'(fifo_level)};
            REG_CTRL:   rdata = {thr_rd, 3'b000, en_q};
            REG_ERR:    rdata = {6'b0, err_q};
            default:    rdata = 8'h00;
        endcase

        ack_d   = req;
        dat_o_d = req ? rdata : 8'h00;
        we_d    = req ? wb_we_i  : we_q;
        adr_d   = req ? wb_adr_i : adr_q;
        wdat_d  = req ? wb_dat_i : wdat_q;

        en_d = ctrl_wr ? wdat_q[CTRL_EN] : en_q;

        err_d = clr_err ? 2'b00 : err_q;
        if (underrun) err_d[ERR_UNDERRUN] = 1'b1;
        if (overflow) err_d[ERR_OVERFLOW] = 1'b1;

        if (!en_q || flush || tick) cnt_d = '0;
        else                        cnt_d = cnt_q + CW'(1);

        pwmin_d = pwmin_q;
        if (flush)    pwmin_d = IDLE_SAMPLE;
        else if (pop) pwmin_d = fifo_dout;

        start_d = en_q & (start_q | tick);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q   <= 1'b0;
            dat_o_q <= 8'h00;
            we_q    <= 1'b0;
            adr_q   <= 2'b00;
            wdat_q  <= 8'h00;
            en_q    <= 1'b0;
            err_q   <= 2'b00;
            cnt_q   <= '0;
            pwmin_q <= IDLE_SAMPLE;
            start_q <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            dat_o_q <= dat_o_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            en_q    <= en_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            pwmin_q <= pwmin_d;
            start_q <= start_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_o_q;
    assign pwmin       = pwmin_q;
    assign cspwm       = en_q;
    assign start_tx_in = start_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Directed bench for pwm_sample_feeder with a short frame; irq steps are
// included when PWM_FEEDER_IRQ_EN is defined.
module tb_pwm_sample_feeder;
    localparam int F = 25;

    logic       clk = 1'b0;
    logic       reset;
    logic       wb_cyc_i, wb_stb_i, wb_we_i;
    logic [1:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic [7:0] pwmin;
    logic       cspwm, start_tx_in;
`ifdef PWM_FEEDER_IRQ_EN
    logic       irq;
`endif

    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] rd;

    pwm_sample_feeder #(.DEPTH(16), .FRAME(F), .IDLE_SAMPLE(8'h80)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .pwmin       (pwmin),
        .cspwm       (cspwm),
        .start_tx_in (start_tx_in)
`ifdef PWM_FEEDER_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the edge at which the access takes effect.
    task automatic wb_access(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                             output logic [7:0] rdat);
        logic got;
        got = 1'b0;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            got = wb_ack_o;
        end
        rdat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        if (!got) begin
            nvec++;
            nerr++;
            $error("FAIL ack_timeout: observed no ack expected ack within 4 cycles");
        end
        cycles(1);
        check("ack_pulse", {7'b0, wb_ack_o}, 8'h00);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [7:0] dat);
        logic [7:0] dummy;
        wb_access(1'b1, adr, dat, dummy);
    endtask

    initial begin
        reset = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 2'd0; wb_dat_i = 8'h00;
        #22;
        check("rst_pwmin", pwmin, 8'h80);
        check("rst_cspwm", {7'b0, cspwm}, 8'h00);
        check("rst_start", {7'b0, start_tx_in}, 8'h00);
        check("rst_ack", {7'b0, wb_ack_o}, 8'h00);
        check("rst_dat_o", wb_dat_o, 8'h00);
`ifdef PWM_FEEDER_IRQ_EN
        check("rst_irq", {7'b0, irq}, 8'h00);
`endif
        @(negedge clk);
        reset = 1'b1;
        cycles(1);
        wb_access(1'b0, 2'd0, 8'h00, rd); check("rd_data_zero", rd, 8'h00);
        wb_access(1'b0, 2'd1, 8'h00, rd); check("rst_status", rd, 8'h20);
        wb_access(1'b0, 2'd3, 8'h00, rd); check("rst_err", rd, 8'h00);
        wb_access(1'b0, 2'd2, 8'h00, rd); check("rst_ctrl", rd, 8'h00);

        // Three samples, then enable and follow one frame per sample.
        wr(2'd0, 8'h10); wr(2'd0, 8'h20); wr(2'd0, 8'h30);
        wb_access(1'b0, 2'd1, 8'h00, rd); check("status_lvl3", rd, 8'h03);
        wr(2'd2, 8'h01);
        check("cspwm_on", {7'b0, cspwm}, 8'h01);
        cycles(F - 1);
        check("pwmin_before_tick", pwmin, 8'h80);
        check("start_before_tick", {7'b0, start_tx_in}, 8'h00);
        cycles(1);
        check("pwmin_s1", pwmin, 8'h10);
        check("start_after_tick", {7'b0, start_tx_in}, 8'h01);
        cycles(F - 1);
        check("pwmin_hold_s1", pwmin, 8'h10);
        cycles(1);
        check("pwmin_s2", pwmin, 8'h20);
        cycles(F);
        check("pwmin_s3", pwmin, 8'h30);
        cycles(F);
        check("pwmin_underrun_hold", pwmin, 8'h30);
        wb_access(1'b0, 2'd3, 8'h00, rd); check("err_underrun", rd, 8'h01);
        wb_access(1'b0, 2'd1, 8'h00, rd); check("status_underrun", rd, 8'hA0);
        wr(2'd2, 8'h05);
        wb_access(1'b0, 2'd2, 8'h00, rd); check("ctrl_selfclear", rd, 8'h01);
        wb_access(1'b0, 2'd3, 8'h00, rd); check("err_cleared", rd, 8'h00);
        wr(2'd2, 8'h00);
        check("cspwm_off", {7'b0, cspwm}, 8'h00);
        cycles(1);
        check("start_off", {7'b0, start_tx_in}, 8'h00);

        // Overfill with EN=0: 17th sample dropped.
        for (int i = 0; i < 17; i++) wr(2'd0, 8'(8'h40 + i));
        wb_access(1'b0, 2'd1, 8'h00, rd); check("status_full", rd, 8'hD0);
        wb_access(1'b0, 2'd3, 8'h00, rd); check("err_overflow", rd, 8'h02);

        // Push landing on the tick cycle while full.
        wr(2'd2, 8'h04);
        wb_access(1'b0, 2'd3, 8'h00, rd); check("err_clr2", rd, 8'h00);
        wr(2'd2, 8'h01);
        cycles(F - 2);
        wr(2'd0, 8'h99);
        check("pwmin_tick_push", pwmin, 8'h40);
        wb_access(1'b0, 2'd1, 8'h00, rd); check("status_tick_push", rd, 8'h50);
        wb_access(1'b0, 2'd3, 8'h00, rd); check("err_tick_push", rd, 8'h00);
        cycles(F - 4);
        check("pwmin_next", pwmin, 8'h41);
        wr(2'd2, 8'h00);
        wb_access(1'b0, 2'd1, 8'h00, rd); check("status_lvl15", rd, 8'h0F);

        wr(2'd2, 8'h02);
        check("flush_pwmin", pwmin, 8'h80);
        wb_access(1'b0, 2'd1, 8'h00, rd); check("flush_status", rd, 8'h20);

        // Asynchronous reset mid-frame with samples queued.
        for (int i = 0; i < 5; i++) wr(2'd0, 8'(8'h61 + i));
        wr(2'd2, 8'h01);
        cycles(F);
        check("pre_rst_pwmin", pwmin, 8'h61);
        check("pre_rst_start", {7'b0, start_tx_in}, 8'h01);
        cycles(5);
        #2;
        reset = 1'b0;
        #1;
        check("arst_pwmin", pwmin, 8'h80);
        check("arst_cspwm", {7'b0, cspwm}, 8'h00);
        check("arst_start", {7'b0, start_tx_in}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        cycles(1);
        wb_access(1'b0, 2'd1, 8'h00, rd); check("arst_status", rd, 8'h20);
        wb_access(1'b0, 2'd2, 8'h00, rd); check("arst_ctrl", rd, 8'h00);

`ifdef PWM_FEEDER_IRQ_EN
        wr(2'd2, 8'h20);
        check("irq_en_off", {7'b0, irq}, 8'h00);
        for (int i = 0; i < 4; i++) wr(2'd0, 8'(8'h71 + i));
        wr(2'd2, 8'h21);
        cycles(2 * F);
        check("irq_lvl2_not_yet", {7'b0, irq}, 8'h00);
        cycles(1);
        check("irq_rise", {7'b0, irq}, 8'h01);
        check("irq_pwmin", pwmin, 8'h72);
        wb_access(1'b0, 2'd2, 8'h00, rd); check("irq_ctrl_thr", rd, 8'h21);
        wr(2'd2, 8'h23);
        check("irq_flush_pwmin", pwmin, 8'h80);
        wb_access(1'b0, 2'd1, 8'h00, rd); check("irq_flush_status", rd, 8'h20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
